// File: rtl/key_schedule_seq.sv
// key_schedule_seq
//   Sequential AES-128/192/256 key expansion. One 32-bit schedule word is
//   produced per clock and stored in a 60-word file. Round keys are read
//   back through a registered port.
//
//   Optional feature macro: KEYSCHED_ZEROIZE_EN
//     defined   -> adds the zeroize input. zeroize clears the word file and
//                  rk_data and returns the FSM to IDLE. Reset also clears
//                  the word file.
//     undefined -> no zeroize port. The word file has no reset.
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     zeroize             (optional) wipe schedule, priority over all else
//     start, key_mode     expansion request: 0=128, 1=192, 2=256, 3=illegal
//     key_in              cipher key, word 0 in the MSBs
//     busy, key_valid     expansion running / schedule readable
//     mode_err            1-cycle pulse after a start with key_mode=3
//     rk_rd, rk_idx       round-key read request
//     rk_data, rk_vld     registered round key, valid pulse
//
//   state  | meaning
//   IDLE   | no schedule held, waiting for start
//   LOAD   | copy the Nk key words into w[0..Nk-1]
//   GEN    | derive one word w[i] per clock
//   DONE   | schedule complete and readable, start accepted again
module key_schedule_seq #(
  parameter int MAX_NK     = 8,
  parameter int MAX_ROUNDS = 14
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                start,
  input  logic [1:0]          key_mode,
  input  logic [32*MAX_NK-1:0] key_in,
  output logic                busy,
  output logic                key_valid,
  output logic                mode_err,
  input  logic                rk_rd,
  input  logic [3:0]          rk_idx,
  output logic [127:0]        rk_data,
  output logic                rk_vld
);

  localparam int NWORDS = 4 * (MAX_ROUNDS + 1);
  localparam int IW     = $clog2(NWORDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      nk_q, nk_d, nr_q, nr_d;
  logic [IW-1:0]   i_q, i_d, left_q, left_d;
  logic [2:0]      j_q, j_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            mode_err_q, mode_err_d;
  logic            load_we, gen_we, zero_req;
  logic [31:0]     wf [NWORDS];
  logic [31:0]     w_prev, w_old, sub_in, sub_out, t_word, gen_word;
  logic [IW-1:0]   rd_base;

`ifdef KEYSCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Only one of RotWord+SubWord / SubWord is needed per word, so the
  // S-box input is muxed and a single 4-byte substitution is shared.
  always_comb begin
    w_prev   = wf[i_q - IW'(1)];
    w_old    = wf[i_q - IW'(nk_q)];
    sub_in   = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out  = subword(sub_in);
    if (j_q == 3'd0)
      t_word = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 3'd4)
      t_word = sub_out;
    else
      t_word = w_prev;
    gen_word = w_old ^ t_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nk_q       <= 4'd4;
      nr_q       <= 4'd0;
      i_q        <= '0;
      j_q        <= '0;
      left_q     <= '0;
      rcon_q     <= 8'h01;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      i_q        <= i_d;
      j_q        <= j_d;
      left_q     <= left_d;
      rcon_q     <= rcon_d;
      mode_err_q <= mode_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    i_d        = i_q;
    j_d        = j_q;
    left_d     = left_q;
    rcon_d     = rcon_q;
    mode_err_d = 1'b0;
    load_we    = 1'b0;
    gen_we     = 1'b0;
    if (zero_req) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            // left counts down the remaining GEN words; 0 marks the last one
            case (key_mode)
              2'd0: begin nk_d = 4'd4; nr_d = 4'd10; left_d = IW'(39); state_d = S_LOAD; end
              2'd1: begin nk_d = 4'd6; nr_d = 4'd12; left_d = IW'(45); state_d = S_LOAD; end
              2'd2: begin nk_d = 4'd8; nr_d = 4'd14; left_d = IW'(51); state_d = S_LOAD; end
              default: mode_err_d = 1'b1;
            endcase
          end
        end
        S_LOAD: begin
          load_we = 1'b1;
          i_d     = IW'(nk_q);
          j_d     = 3'd0;
          rcon_d  = 8'h01;
          state_d = S_GEN;
        end
        S_GEN: begin
          gen_we = 1'b1;
          i_d    = i_q + IW'(1);
          j_d    = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
          if (j_q == 3'd0)
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          if (left_q == '0)
            state_d = S_DONE;
          else
            left_d = left_q - IW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_LOAD) || (state_q == S_GEN);
  assign key_valid = (state_q == S_DONE);
  assign mode_err  = mode_err_q;

`ifdef KEYSCHED_ZEROIZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NWORDS; k++) wf[k] <= '0;
    end else if (zeroize) begin
      for (int k = 0; k < NWORDS; k++) wf[k] <= '0;
    end else if (load_we) begin
      for (int k = 0; k < MAX_NK; k++)
        if (k < int'(nk_q)) wf[k] <= key_in[32*(MAX_NK-1-k) +: 32];
    end else if (gen_we) begin
      wf[i_q] <= gen_word;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (load_we) begin
      for (int k = 0; k < MAX_NK; k++)
        if (k < int'(nk_q)) wf[k] <= key_in[32*(MAX_NK-1-k) +: 32];
    end else if (gen_we) begin
      wf[i_q] <= gen_word;
    end
  end
`endif

  assign rd_base = IW'({rk_idx, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data <= '0;
      rk_vld  <= 1'b0;
    end else if (zero_req) begin
      rk_data <= '0;
      rk_vld  <= 1'b0;
    end else begin
      rk_vld <= rk_rd;
      if (rk_rd) begin
        if (key_valid && rk_idx <= nr_q)
          rk_data <= {wf[rd_base], wf[rd_base + IW'(1)],
                      wf[rd_base + IW'(2)], wf[rd_base + IW'(3)]};
        else
          rk_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq. Round-key reads push their
// expected value into a queue; a monitor pops and compares on each rk_vld.
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_mode = 2'd0;
  logic [255:0] key_in = '0;
  logic         busy, key_valid, mode_err;
  logic         rk_rd = 1'b0;
  logic [3:0]   rk_idx = 4'd0;
  logic [127:0] rk_data;
  logic         rk_vld;
`ifdef KEYSCHED_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] d;
    int           idx;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'hdeadbeef0123456789abcdeffedcba98};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                   64'h0123456789abcdef};
  localparam logic [255:0] K256 = {128'h603deb1015ca71be2b73aef0857d7781,
                                   128'h1f352c073b6108d72d9810a30914dff4};

  key_schedule_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .start     (start),
    .key_mode  (key_mode),
    .key_in    (key_in),
    .busy      (busy),
    .key_valid (key_valid),
    .mode_err  (mode_err),
    .rk_rd     (rk_rd),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .rk_vld    (rk_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rk_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rk_vld_unexpected actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("rk_data_idx%0d", e.idx), rk_data, e.d);
      end
    end
  end

  task automatic rd(input int idx, input logic [127:0] exp);
    exp_t e;
    e.d = exp;
    e.idx = idx;
    exp_q.push_back(e);
    rk_rd = 1'b1;
    rk_idx = 4'(idx);
    @(posedge clk);
    #1;
    rk_rd = 1'b0;
  endtask

  // poke > 0 raises start (with mode 0) so that it is sampled at GEN edge 'poke'
  task automatic expand(input logic [1:0] mode, input logic [255:0] key,
                        input int exp_lat, input int poke, input string nm);
    int n;
    start = 1'b1;
    key_mode = mode;
    key_in = key;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busy_at_e0"}, 128'(busy), 128'(1));
    chk({nm, "_kv_at_e0"}, 128'(key_valid), 128'(0));
    n = 0;
    while (!key_valid && n < 100) begin
      if (poke > 0 && n == poke) begin
        start = 1'b1;
        key_mode = 2'd0;
      end
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      key_mode = mode;
    end
    chk({nm, "_latency"}, 128'(n), 128'(exp_lat));
    chk({nm, "_busy_done"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_key_valid", 128'(key_valid), 128'(0));
    chk("reset_mode_err", 128'(mode_err), 128'(0));
    chk("reset_rk_vld", 128'(rk_vld), 128'(0));
    chk("reset_rk_data", rk_data, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // AES-128
    expand(2'd0, K128, 41, 0, "aes128");
    rd(0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd(1,  128'ha0fafe1788542cb123a339392a6c7605);
    rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(11, 128'h0);

    // AES-192
    expand(2'd1, K192, 47, 0, "aes192");
    rd(1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    rd(12, 128'he98ba06f448c773c8ecc720401002202);
    rd(13, 128'h0);

    // illegal mode keeps the AES-192 schedule
    start = 1'b1;
    key_mode = 2'd3;
    key_in = K128;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mode3_err_pulse", 128'(mode_err), 128'(1));
    chk("mode3_busy", 128'(busy), 128'(0));
    chk("mode3_kv_kept", 128'(key_valid), 128'(1));
    @(posedge clk);
    #1;
    chk("mode3_err_cleared", 128'(mode_err), 128'(0));
    rd(12, 128'he98ba06f448c773c8ecc720401002202);

    // AES-256 with a start poked at GEN edge 10
    expand(2'd2, K256, 53, 10, "aes256");
    rd(0,  128'h603deb1015ca71be2b73aef0857d7781);
    rd(2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    rd(14, 128'hfe4890d1e6188d0b046df344706c631e);
    rd(15, 128'h0);

    // reset at GEN edge 20 of an AES-128 run
    start = 1'b1;
    key_mode = 2'd0;
    key_in = K128;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("midrun_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 128'(busy), 128'(0));
    chk("async_rst_kv", 128'(key_valid), 128'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(3, 128'h0);
    expand(2'd0, K128, 41, 0, "restart128");
    rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(11, 128'h0);

`ifdef KEYSCHED_ZEROIZE_EN
    expand(2'd2, K256, 53, 0, "zero_pre256");
    zeroize = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    chk("zeroize_kv", 128'(key_valid), 128'(0));
    chk("zeroize_busy", 128'(busy), 128'(0));
    chk("zeroize_rk_data", rk_data, 128'h0);
    rd(0, 128'h0);
    expand(2'd0, K128, 41, 0, "zero_post128");
    rd(11, 128'h0);
    rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drain", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
